// File: rtl/lpf_integrate_dump_pkg.sv
// ============================================================================
// Module      : lpf_pkg
// Description : Shared types and width helper for the integrate/dump LPF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package lpf_pkg;

    typedef enum logic {
        LPF_MOVING = 1'b0,
        LPF_DUMP   = 1'b1
    } lpf_mode_e;

    function automatic int lpf_out_width(input int data_w, input int depth);
        return data_w + $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/lpf_integrate_dump_if.sv
// ============================================================================
// Module      : lpf_integrate_dump_if
// Description : Sample-in / result-out bundle for lpf_integrate_dump.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface lpf_integrate_dump_if
    import lpf_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 8
);
    localparam int c_OUT_WIDTH = lpf_out_width(DATA_WIDTH, DEPTH);

    logic                          in_valid;
    logic signed [DATA_WIDTH-1:0]  in_data;
    lpf_mode_e                     mode;
    logic [$clog2(DEPTH):0]        sym_len;
    logic                          clear;
    logic                          out_valid;
    logic signed [c_OUT_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, mode, sym_len, clear,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, mode, sym_len, clear,
        output out_valid, out_data
    );

endinterface

`default_nettype wire

// File: rtl/lpf_integrate_dump_delay_line.sv
// ============================================================================
// Module      : lpf_delay_line
// Description : DEPTH-entry circular sample buffer; presents the oldest entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lpf_delay_line #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_wr_en,
    input  logic signed [DATA_WIDTH-1:0] i_wr_data,
    output logic signed [DATA_WIDTH-1:0] o_oldest
);
    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW-1:0]              r_wptr;
    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

    // The slot about to be overwritten holds the sample from DEPTH writes ago.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_clear) begin
            r_wptr <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_data;
            r_wptr        <= r_wptr + c_AW'(1);
        end
    end

    assign o_oldest = r_mem[r_wptr];

endmodule

`default_nettype wire

// File: rtl/lpf_integrate_dump.sv
// ============================================================================
// Module      : lpf_integrate_dump
// Description : Clocked boxcar LPF / integrate-and-dump; LPF_AVG_EN selects
//               rounded divide-by-DEPTH output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lpf_integrate_dump
    import lpf_pkg::*;
#(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 8,
    parameter int OUT_WIDTH  = lpf_out_width(DATA_WIDTH, DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lpf_integrate_dump_if.slave  bus
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam logic [c_LW-1:0] c_DEPTH_L = c_LW'(DEPTH);

    logic                        r_armed;
    lpf_mode_e                   r_mode;
    logic signed [OUT_WIDTH-1:0] r_acc;
    logic [c_LW-1:0]             r_count;
    logic [c_LW-1:0]             r_len;
    logic                        r_out_valid;
    logic signed [OUT_WIDTH-1:0] r_out_data;

    logic                         w_flush;
    logic                         w_dl_wr;
    logic signed [DATA_WIDTH-1:0] w_oldest;
    logic signed [OUT_WIDTH-1:0]  w_in_ext;
    logic signed [OUT_WIDTH-1:0]  w_old_ext;
    logic signed [OUT_WIDTH-1:0]  w_move_sum;
    logic signed [OUT_WIDTH-1:0]  w_dump_sum;
    logic [c_LW-1:0]              w_len_eff;
    logic [c_LW-1:0]              w_cur_len;
    logic                         w_last;

`ifdef LPF_AVG_EN
    localparam logic signed [OUT_WIDTH-1:0] c_HALF = OUT_WIDTH'(2 ** (c_AW - 1));

    function automatic logic signed [OUT_WIDTH-1:0] f_scale(input logic signed [OUT_WIDTH-1:0] s);
        logic signed [OUT_WIDTH-1:0] rounded;
        rounded = s + c_HALF;
        return rounded >>> c_AW;
    endfunction
`else
    function automatic logic signed [OUT_WIDTH-1:0] f_scale(input logic signed [OUT_WIDTH-1:0] s);
        return s;
    endfunction
`endif

    // Mode compare is suppressed on the first cycle out of reset, which
    // already starts from a flushed state, so no sample is lost there.
    assign w_flush = bus.clear | (r_armed & (bus.mode != r_mode));
    assign w_dl_wr = bus.in_valid & ~w_flush & (bus.mode == LPF_MOVING);

    lpf_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_delay_line (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_flush),
        .i_wr_en   (w_dl_wr),
        .i_wr_data (bus.in_data),
        .o_oldest  (w_oldest)
    );

    assign w_in_ext   = {{(OUT_WIDTH-DATA_WIDTH){bus.in_data[DATA_WIDTH-1]}}, bus.in_data};
    assign w_old_ext  = {{(OUT_WIDTH-DATA_WIDTH){w_oldest[DATA_WIDTH-1]}}, w_oldest};
    assign w_move_sum = r_acc + w_in_ext - w_old_ext;
    assign w_dump_sum = r_acc + w_in_ext;

    assign w_len_eff = ((bus.sym_len == '0) || (bus.sym_len > c_DEPTH_L)) ? c_DEPTH_L : bus.sym_len;
    assign w_cur_len = (r_count == '0) ? w_len_eff : r_len;
    assign w_last    = ((r_count + c_LW'(1)) == w_cur_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_mode      <= LPF_MOVING;
            r_acc       <= '0;
            r_count     <= '0;
            r_len       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_armed     <= 1'b1;
            r_mode      <= bus.mode;
            r_out_valid <= 1'b0;
            if (w_flush) begin
                r_acc   <= '0;
                r_count <= '0;
                r_len   <= '0;
            end else if (bus.in_valid) begin
                if (bus.mode == LPF_MOVING) begin
                    r_acc       <= w_move_sum;
                    r_out_valid <= 1'b1;
                    r_out_data  <= f_scale(w_move_sum);
                end else if (w_last) begin
                    r_acc       <= '0;
                    r_count     <= '0;
                    r_out_valid <= 1'b1;
                    r_out_data  <= f_scale(w_dump_sum);
                end else begin
                    r_acc   <= w_dump_sum;
                    r_count <= r_count + c_LW'(1);
                    if (r_count == '0) r_len <= w_len_eff;
                end
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;

endmodule

`default_nettype wire

// File: doc/lpf_integrate_dump.md
# lpf_integrate_dump

Streaming low-pass integrator for the BPSK receive path, sitting between the mixer/decimator output and the symbol slicer. It replaces the combinational array-sum integrator with a clocked block that accepts one sample per valid cycle. It operates either as a DEPTH-tap moving sum (boxcar LPF) or as an integrate-and-dump over a programmable symbol length. A mode switch, synchronous clear and optional averaging let one instance serve both carrier-recovery filtering and matched-filter symbol integration.

## Interface
- DATA_WIDTH, 18, signed input sample width
- DEPTH, 8, moving-sum window length and maximum dump length; power of two, 2..256
- OUT_WIDTH, DATA_WIDTH+$clog2(DEPTH), output width (derived; not overridden)
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  sample strobe; in_data accepted on any cycle it is high (no backpressure)
- in_data  in  DATA_WIDTH  signed two's-complement sample
- mode  in  1  0 = moving sum, 1 = integrate-and-dump
- sym_len  in  $clog2(DEPTH)+1  dump length in samples; 0 or >DEPTH treated as DEPTH; sampled at the start of each dump window
- clear  in  1  synchronous flush of accumulator, delay line and counters
- out_valid  out  1  one-cycle result strobe
- out_data  out  OUT_WIDTH  signed result, held between strobes

## Operation
- Moving mode: DEPTH-entry circular delay line, write pointer wraps DEPTH-1 -> 0. Per accepted sample: acc <= acc + in_data - oldest; oldest slot overwritten. Delay line zero after reset/clear, so the first DEPTH outputs are partial sums (no warm-up gating). out_valid pulses once per accepted sample.
- Dump mode: acc accumulates accepted samples; count runs 1..len. On the len-th sample out_data <= acc + in_data, out_valid pulses, acc and count return to 0. Delay line is not written in dump mode.
- Arithmetic: full-precision sign-extended OUT_WIDTH sums; DEPTH samples of any DATA_WIDTH value cannot overflow, so no wrap or saturation is needed.
- A change of mode (detected against a registered copy) acts as clear on the same cycle.
- Priority per cycle: rst_n > clear/mode change > in_valid. A sample arriving with clear is discarded and produces no out_valid.
- Reset mid-window: the partial sum is lost, out_data = 0, and counting restarts from the first sample after release.
- in_valid gaps of any length are allowed; state holds while in_valid is low.

## Timing
- Reset values: out_valid = 0, out_data = 0, acc = 0, pointers/count = 0, delay line = 0.
- Latency: 1 cycle, in_valid at edge N -> out_valid/out_data at edge N+1.
- Throughput: one sample per cycle sustained, back-to-back in_valid supported.
- out_valid is high for exactly one cycle per result. out_data changes only with out_valid.
- sym_len is latched when count = 0 and a sample is accepted. Changes mid-window take effect on the next window.

## Configuration
- LPF_AVG_EN defined: out_data = sum arithmetically shifted right by $clog2(DEPTH), rounded half-up (add 2^($clog2(DEPTH)-1) before the shift), then sign-extended to OUT_WIDTH. The result is a mean in moving mode and a scaled sum in dump mode.
- LPF_AVG_EN undefined: out_data = full-precision sum. No rounding logic is present.

## Structure
- Package lpf_pkg: lpf_mode_e enum (LPF_MOVING = 0, LPF_DUMP = 1) and function lpf_out_width(data_w, depth).
- Sub-module lpf_delay_line: DEPTH x DATA_WIDTH circular buffer with write pointer. It presents the oldest entry combinationally, and takes a synchronous clear input and the asynchronous rst_n.

## Test plan
- Moving, DEPTH=8, DATA_WIDTH=18: feed i*1024 for i = 0..7 -> 8th out_data = 28672. Then feed 0, 0 -> 28672, then 27648.
- Dump, sym_len=4: feed 1024, 2048, 3072, 4096 -> a single out_valid with out_data = 10240, one cycle after the 4th sample. A following window restarts from 0.
- Extremes: 8 samples of 131071 -> 1048568; 8 samples of -131072 -> -1048576. No wrap.
- Clear asserted with in_valid and in_data = 5000 -> no out_valid. The next sample of 1024 yields 1024 in both modes.
- Reset mid-dump after 2 samples -> out_data = 0 and out_valid = 0 immediately. After release a full sym_len window is required before the next output.
- LPF_AVG_EN, moving mode: the 0..7 ramp -> 8th out_data = 3584. Sum 4 (e.g. samples 4, 0 x7) -> rounds to 1.
